// File: rtl/aibcr3_dcc_cal_ctrl.sv
// rtl/aibcr3_dcc_cal_ctrl.sv - DCC delay-line SAR calibration sequencer
//
// Purpose: drives the 11-bit delay code (coarse i_gray, fine f_gray) of the
// DCC macro, pulses launch/measure, samples the phase detector and runs an
// 11-step successive-approximation search, then holds the code and asserts
// dll_lock.
//
// Optional feature: define DCC_CAL_MAJ_EN to take three launch/measure/sample
// rounds per bit and decide by majority vote.
//
// Ports:
//   clk          controller clock
//   reset        synchronous, active-high reset
//   cal_start    one-cycle pulse, starts or restarts calibration
//   t_up/t_down  asynchronous phase-detector outputs
//   dll_reset_n  active-low reset to the DCC macro
//   dll_lock     code final, macro on locked path
//   launch       one-cycle launch pulse
//   measure      one-cycle measure pulse
//   i_gray       gray(code[10:8])
//   f_gray       gray(code[7:0])
//   cal_code     current binary code
//   cal_done     calibration complete (level)
//   cal_err      sticky: t_up and t_down both high at a sample
module aibcr3_dcc_cal_ctrl #(
  parameter int RST_CYC    = 8,
  parameter int SETTLE_CYC = 16,
  parameter int SAMPLE_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cal_start,
  input  logic        t_up,
  input  logic        t_down,
  output logic        dll_reset_n,
  output logic        dll_lock,
  output logic        launch,
  output logic        measure,
  output logic [2:0]  i_gray,
  output logic [7:0]  f_gray,
  output logic [10:0] cal_code,
  output logic        cal_done,
  output logic        cal_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_SETTLE, S_LAUNCH, S_MEAS, S_SAMPLE, S_DECIDE, S_LOCK, S_DONE
  } state_t;

  localparam int CNT_MAX = (RST_CYC > SETTLE_CYC) ?
                           ((RST_CYC > SAMPLE_CYC) ? RST_CYC : SAMPLE_CYC) :
                           ((SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t RST_LAST    = cnt_t'(RST_CYC - 1);
  localparam cnt_t SETTLE_LAST = cnt_t'(SETTLE_CYC - 1);
  localparam cnt_t SAMPLE_LAST = cnt_t'(SAMPLE_CYC - 1);

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [10:0] code_q, code_d;
  logic [3:0]  idx_q, idx_d;
  logic        dec_q, dec_d;
  logic        err_q, err_d;
  logic        lock_q, lock_d;
  logic        done_q, done_d;
  logic        rstn_q, rstn_d;
  logic        launch_q, measure_q;
  logic [2:0]  i_gray_q;
  logic [7:0]  f_gray_q;
  logic        up_s1, up_s2, dn_s1, dn_s2;
`ifdef DCC_CAL_MAJ_EN
  logic [1:0]  rep_q, rep_d;
  logic [1:0]  votes_q, votes_d;
  logic [1:0]  votes_sum;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    err_d   = err_q;
    lock_d  = lock_q;
    done_d  = done_q;
    rstn_d  = rstn_q;
`ifdef DCC_CAL_MAJ_EN
    rep_d     = rep_q;
    votes_d   = votes_q;
    votes_sum = votes_q + {1'b0, up_s2};
`endif
    case (state_q)
      S_IDLE: rstn_d = 1'b1;
      S_RST: begin
        if (cnt_q == RST_LAST) begin
          rstn_d  = 1'b1;
          code_d  = 11'h400;
          idx_d   = 4'd10;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_LAUNCH;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_LAUNCH: state_d = S_MEAS;
      S_MEAS: begin
        cnt_d   = '0;
        state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d = '0;
          // Both detector outputs high is a contradiction; flag it and treat
          // the sample as "too short" so the search still converges.
          if (up_s2 && dn_s2) err_d = 1'b1;
`ifdef DCC_CAL_MAJ_EN
          if (rep_q == 2'd2) begin
            dec_d   = (votes_sum >= 2'd2);
            rep_d   = '0;
            votes_d = '0;
            state_d = S_DECIDE;
          end else begin
            rep_d   = rep_q + 2'd1;
            votes_d = votes_sum;
            state_d = S_LAUNCH;
          end
`else
          dec_d   = up_s2;
          state_d = S_DECIDE;
`endif
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_DECIDE: begin
        if (!dec_q) code_d[idx_q] = 1'b0;
        if (idx_q != 4'd0) begin
          code_d[idx_q - 4'd1] = 1'b1;
          idx_d   = idx_q - 4'd1;
          state_d = S_SETTLE;
        end else begin
          state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        lock_d  = 1'b1;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    // cal_start from any state (re)starts from a clean macro reset.
    if (cal_start) begin
      state_d = S_RST;
      cnt_d   = '0;
      code_d  = '0;
      idx_d   = 4'd10;
      dec_d   = 1'b0;
      err_d   = 1'b0;
      lock_d  = 1'b0;
      done_d  = 1'b0;
      rstn_d  = 1'b0;
`ifdef DCC_CAL_MAJ_EN
      rep_d   = '0;
      votes_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      code_q    <= '0;
      idx_q     <= 4'd10;
      dec_q     <= 1'b0;
      err_q     <= 1'b0;
      lock_q    <= 1'b0;
      done_q    <= 1'b0;
      rstn_q    <= 1'b0;
      launch_q  <= 1'b0;
      measure_q <= 1'b0;
      i_gray_q  <= '0;
      f_gray_q  <= '0;
      up_s1     <= 1'b0;
      up_s2     <= 1'b0;
      dn_s1     <= 1'b0;
      dn_s2     <= 1'b0;
`ifdef DCC_CAL_MAJ_EN
      rep_q     <= '0;
      votes_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      idx_q     <= idx_d;
      dec_q     <= dec_d;
      err_q     <= err_d;
      lock_q    <= lock_d;
      done_q    <= done_d;
      rstn_q    <= rstn_d;
      // Pulses and gray code are registered from next-state values so they
      // line up exactly with the state/code they belong to.
      launch_q  <= (state_d == S_LAUNCH);
      measure_q <= (state_d == S_MEAS);
      i_gray_q  <= code_d[10:8] ^ (code_d[10:8] >> 1);
      f_gray_q  <= code_d[7:0] ^ (code_d[7:0] >> 1);
      up_s1     <= t_up;
      up_s2     <= up_s1;
      dn_s1     <= t_down;
      dn_s2     <= dn_s1;
`ifdef DCC_CAL_MAJ_EN
      rep_q     <= rep_d;
      votes_q   <= votes_d;
`endif
    end
  end

  assign dll_reset_n = rstn_q;
  assign dll_lock    = lock_q;
  assign launch      = launch_q;
  assign measure     = measure_q;
  assign i_gray      = i_gray_q;
  assign f_gray      = f_gray_q;
  assign cal_code    = code_q;
  assign cal_done    = done_q;
  assign cal_err     = err_q;

endmodule

// File: tb/tb_aibcr3_dcc_cal_ctrl.sv
// tb/tb_aibcr3_dcc_cal_ctrl.sv - scoreboard bench for aibcr3_dcc_cal_ctrl
module tb_aibcr3_dcc_cal_ctrl;

  localparam int M_ONE  = 0;
  localparam int M_ZERO = 1;
  localparam int M_THR  = 2;
  localparam int M_BOTH = 3;

`ifdef DCC_CAL_MAJ_EN
  localparam int EXP_PULSES = 33;
  localparam int EXP_LAT    = 1 + 8 + 11 * (16 + 3 * (4 + 2) + 1);
`else
  localparam int EXP_PULSES = 11;
  localparam int EXP_LAT    = 1 + 8 + 11 * (16 + 4 + 3);
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cal_start = 1'b0;
  logic        t_up, t_down;
  logic        dll_reset_n, dll_lock, launch, measure, cal_done, cal_err;
  logic [2:0]  i_gray;
  logic [7:0]  f_gray;
  logic [10:0] cal_code;

  int mode = M_ZERO;
  int thr  = 0;
  int cyc  = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int code;
    int err;
    int lat;
  } exp_t;
  exp_t sb[$];

  aibcr3_dcc_cal_ctrl dut (
    .clk(clk), .reset(reset), .cal_start(cal_start),
    .t_up(t_up), .t_down(t_down),
    .dll_reset_n(dll_reset_n), .dll_lock(dll_lock),
    .launch(launch), .measure(measure),
    .i_gray(i_gray), .f_gray(f_gray), .cal_code(cal_code),
    .cal_done(cal_done), .cal_err(cal_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Phase detector model: responds to the code currently driven to the macro.
  always_comb begin
    t_up   = 1'b0;
    t_down = 1'b0;
    case (mode)
      M_ONE:  begin t_up = 1'b1; t_down = 1'b0; end
      M_ZERO: begin t_up = 1'b0; t_down = 1'b1; end
      M_THR:  begin t_up = (int'(cal_code) <= thr); t_down = !(int'(cal_code) <= thr); end
      default: begin t_up = 1'b1; t_down = 1'b1; end
    endcase
  end

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic bit pd_decide(input int m, input int t, input int c);
    case (m)
      M_ONE:  return 1'b1;
      M_ZERO: return 1'b0;
      M_THR:  return c <= t;
      default: return 1'b1;
    endcase
  endfunction

  // SAR result: the largest code whose decision is "too short", else 0.
  function automatic int sar_ref(input int m, input int t);
    for (int c = 2047; c >= 0; c--)
      if (pd_decide(m, t, c)) return c;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: tracks pulses per run and compares against the scoreboard when
  // cal_done rises.
  int  nl, nm, nrst, first_code, start_cyc;
  bit  running = 0, got_first = 0, overlap = 0;
  logic prev_done = 1'b0, prev_rstn = 1'b0;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      running = 0;
    end else begin
      if (cal_start) begin
        running = 1; nl = 0; nm = 0; nrst = 0;
        got_first = 0; overlap = 0; first_code = -1; start_cyc = cyc;
      end
      if (running) begin
        if (launch) nl++;
        if (measure) nm++;
        if (launch && measure) overlap = 1;
        if (!dll_reset_n) nrst++;
        if (!got_first && dll_reset_n && !prev_rstn) begin
          first_code = int'(cal_code);
          got_first = 1;
        end
      end
      if (cal_done && !prev_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("cal_code", int'(cal_code), e.code);
          check("i_gray", int'(i_gray), gray(e.code >> 8));
          check("f_gray", int'(f_gray), gray(e.code & 8'hFF));
          check("dll_lock", int'(dll_lock), 1);
          check("cal_err", int'(cal_err), e.err);
          check("latency", cyc - start_cyc, e.lat);
          check("launch_cnt", nl, EXP_PULSES);
          check("measure_cnt", nm, EXP_PULSES);
          check("rst_low_cyc", nrst, 8);
          check("first_code", first_code, 'h400);
          check("no_overlap", int'(overlap), 0);
        end
        running = 0;
      end
    end
    prev_done = cal_done;
    prev_rstn = dll_reset_n;
  end

  task automatic pulse_start();
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cal_done) begin
        seen = 1;
        break;
      end
    end
    check("done_seen", int'(seen), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic push_exp(input int m, input int t);
    exp_t e;
    e.code = sar_ref(m, t);
    e.err  = (m == M_BOTH);
    e.lat  = EXP_LAT;
    sb.push_back(e);
  endtask

  task automatic run(input int m, input int t);
    mode = m;
    thr  = t;
    push_exp(m, t);
    pulse_start();
    wait_done();
  endtask

  task automatic check_idle_outputs(input string tag, input int rstn_exp, input int err_exp);
    check({tag, "_rstn"}, int'(dll_reset_n), rstn_exp);
    check({tag, "_lock"}, int'(dll_lock), 0);
    check({tag, "_launch"}, int'(launch), 0);
    check({tag, "_measure"}, int'(measure), 0);
    check({tag, "_code"}, int'(cal_code), 0);
    check({tag, "_gray"}, int'({i_gray, f_gray}), 0);
    check({tag, "_done"}, int'(cal_done), 0);
    check({tag, "_err"}, int'(cal_err), err_exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset", 0, 0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check_idle_outputs("idle", 1, 0);

    run(M_ONE, 0);
    run(M_ZERO, 0);
    run(M_THR, 1000);
    run(M_BOTH, 0);
    repeat (20) @(negedge clk);
    check("err_sticky", int'(cal_err), 1);
    check("done_held", int'(cal_done), 1);

    // Restart from DONE clears the sticky error and lock immediately.
    mode = M_THR;
    thr  = 2047;
    push_exp(M_THR, 2047);
    pulse_start();
    check("err_cleared", int'(cal_err), 0);
    check("lock_dropped", int'(dll_lock), 0);
    wait_done();

    run(M_THR, 0);

    // Abort the search around bit 5 and let the restarted search finish.
    mode = M_THR;
    thr  = int'($urandom_range(0, 2047));
    pulse_start();
    repeat (129) @(negedge clk);
    push_exp(M_THR, thr);
    pulse_start();
    wait_done();

    // Reset in the middle of a search forces every output back to reset values.
    mode = M_BOTH;
    pulse_start();
    repeat (100) @(negedge clk);
    check("err_before_reset", int'(cal_err), 1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset", 0, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 6; k++)
      run(M_THR, int'($urandom_range(0, 2047)));

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
